// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - multi-channel debouncer with level/pulse/hold/repeat output modes
module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 26,
    parameter int STABLE_CYCLES = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int RPT_DELAY     = 25000000,
    parameter int RPT_PERIOD    = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] signal,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] rel,
    output logic [CHANNELS-1:0] debounced
);
    // 'release' is a reserved word, so the falling-edge pulse port is named rel.
    localparam logic [1:0] M_LEVEL  = 2'b00;
    localparam logic [1:0] M_PULSE  = 2'b01;
    localparam logic [1:0] M_HOLD   = 2'b10;

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RPT_DELAY, S_RPT_RUN} state_t;

    logic [1:0] mode_q;
    logic       mode_chg;

    always_ff @(posedge clk) begin
        mode_q <= mode;
    end

    assign mode_chg = (mode != mode_q);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             sync1, sync2;
        logic             lvl_r, press_r, rel_r, deb_r;
        logic [CNT_W-1:0] cnt, timer;
        state_t           state;
        logic             accept, lvl_n, rise;

        // Mode FSM reacts to the post-edge level so pulses never outlive the level.
        always_comb begin
            accept = (sync2 != lvl_r) && (cnt == STABLE_LAST);
            lvl_n  = accept ? sync2 : lvl_r;
            rise   = accept && sync2;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1   <= 1'b0;
                sync2   <= 1'b0;
                cnt     <= '0;
                timer   <= '0;
                lvl_r   <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
                deb_r   <= 1'b0;
                state   <= S_IDLE;
            end else begin
                sync1   <= signal[i];
                sync2   <= sync1;
                cnt     <= (sync2 == lvl_r || accept) ? '0 : cnt + ONE;
                lvl_r   <= lvl_n;
                press_r <= rise;
                rel_r   <= accept && !sync2;
                if (mode_chg) begin
                    state <= S_IDLE;
                    timer <= '0;
                    deb_r <= 1'b0;
                end else begin
                    case (mode)
                        M_LEVEL: begin
                            state <= S_IDLE;
                            timer <= '0;
                            deb_r <= lvl_n;
                        end
                        M_PULSE: begin
                            state <= S_IDLE;
                            timer <= '0;
                            deb_r <= rise;
                        end
                        M_HOLD: begin
                            case (state)
                                S_IDLE: begin
                                    timer <= '0;
                                    deb_r <= rise;
                                    if (rise) state <= S_HOLD;
                                end
                                S_HOLD: begin
                                    if (timer == HOLD_LAST) begin
                                        state <= S_IDLE;
                                        timer <= '0;
                                        deb_r <= 1'b0;
                                    end else begin
                                        timer <= timer + ONE;
                                        deb_r <= 1'b1;
                                    end
                                end
                                default: begin
                                    state <= S_IDLE;
                                    timer <= '0;
                                    deb_r <= 1'b0;
                                end
                            endcase
                        end
                        default: begin
                            case (state)
                                S_IDLE: begin
                                    timer <= '0;
                                    deb_r <= rise;
                                    if (rise) state <= S_RPT_DELAY;
                                end
                                S_RPT_DELAY, S_RPT_RUN: begin
                                    if (!lvl_n) begin
                                        state <= S_IDLE;
                                        timer <= '0;
                                        deb_r <= 1'b0;
                                    end else if ((state == S_RPT_DELAY && timer == DELAY_LAST) ||
                                                 (state == S_RPT_RUN && timer == PERIOD_LAST)) begin
                                        state <= S_RPT_RUN;
                                        timer <= '0;
                                        deb_r <= 1'b1;
                                    end else begin
                                        timer <= timer + ONE;
                                        deb_r <= 1'b0;
                                    end
                                end
                                default: begin
                                    state <= S_IDLE;
                                    timer <= '0;
                                    deb_r <= 1'b0;
                                end
                            endcase
                        end
                    endcase
                end
            end
        end

        assign level[i]     = lvl_r;
        assign press[i]     = press_r;
        assign rel[i]       = rel_r;
        assign debounced[i] = deb_r;
    end
endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - table, directed and randomized checks of multi_debouncer
module tb_multi_debouncer;
    localparam int CH = 2, CW = 8, STB = 4, HLD = 6, RD = 10, RP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] signal = '0;
    logic [1:0]    mode = 2'b00;
    logic [CH-1:0] level, press, rel, debounced;

    always #5 clk = ~clk;

    multi_debouncer #(
        .CHANNELS(CH), .CNT_W(CW), .STABLE_CYCLES(STB),
        .HOLD_CYCLES(HLD), .RPT_DELAY(RD), .RPT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .signal(signal), .mode(mode),
        .level(level), .press(press), .rel(rel), .debounced(debounced)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Reference model: level flips once the last STB synchronized samples all differ from it.
    bit          hist [CH][STB+2];
    bit [CH-1:0] m_lvl, m_prs, m_rel, m_deb;
    bit          m_act [CH];
    int          m_age [CH];
    bit [1:0]    m_prev = 2'b00;

    task automatic model_edge(input bit r, input bit [CH-1:0] s, input bit [1:0] m);
        bit mchg, diff, nl, rise;
        mchg   = (m != m_prev);
        m_prev = m;
        for (int c = 0; c < CH; c++) begin
            for (int k = STB + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = r ? 1'b0 : s[c];
            if (r) begin
                for (int k = 0; k < STB + 2; k++) hist[c][k] = 1'b0;
                m_lvl[c] = 0; m_prs[c] = 0; m_rel[c] = 0; m_deb[c] = 0;
                m_act[c] = 0; m_age[c] = 0;
            end else begin
                diff = 1'b1;
                for (int k = 2; k < STB + 2; k++) if (hist[c][k] == m_lvl[c]) diff = 1'b0;
                nl   = diff ? !m_lvl[c] : m_lvl[c];
                rise = diff && nl;
                m_prs[c] = rise;
                m_rel[c] = diff && !nl;
                m_lvl[c] = nl;
                if (mchg || m == 2'd0 || m == 2'd1) begin
                    m_act[c] = 0;
                    m_age[c] = 0;
                    m_deb[c] = mchg ? 1'b0 : ((m == 2'd0) ? nl : rise);
                end else if (m_act[c]) begin
                    m_age[c]++;
                    if (m == 2'd2) begin
                        if (m_age[c] == HLD) begin m_act[c] = 0; m_deb[c] = 0; end
                        else m_deb[c] = 1;
                    end else if (!nl) begin
                        m_act[c] = 0;
                        m_deb[c] = 0;
                    end else begin
                        m_deb[c] = (m_age[c] == RD) || (m_age[c] > RD && (m_age[c] - RD) % RP == 0);
                    end
                end else begin
                    m_act[c] = rise;
                    m_age[c] = 0;
                    m_deb[c] = rise;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit [CH-1:0] s, input bit [1:0] m);
        rst = r; signal = s; mode = m;
        @(posedge clk);
        model_edge(r, s, m);
        #1;
        cyc++;
        chk("model_level", level, m_lvl);
        chk("model_press", press, m_prs);
        chk("model_release", rel, m_rel);
        chk("model_debounced", debounced, m_deb);
    endtask

    typedef struct {
        bit       rst;
        bit [1:0] sig;
        bit [1:0] mode;
        bit [1:0] lvl;
        bit [1:0] prs;
        bit [1:0] rls;
        bit [1:0] deb;
    } vec_t;

    function automatic vec_t mk(bit r, bit [1:0] s, bit [1:0] l, bit [1:0] p, bit [1:0] e, bit [1:0] d);
        vec_t v;
        v.rst = r; v.sig = s; v.mode = 2'b00; v.lvl = l; v.prs = p; v.rls = e; v.deb = d;
        return v;
    endfunction

    vec_t     tbl[$];
    int       hold_cnt, n_pulse;
    int       run [CH];
    bit       e;
    bit       rr;
    bit [1:0] rm;
    bit [CH-1:0] rs;

    initial begin
        tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        repeat (5) tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01));
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01));
        repeat (5) tbl.push_back(mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        repeat (3) tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
        repeat (6) tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].sig, tbl[i].mode);
            chk("tbl_level", level, tbl[i].lvl);
            chk("tbl_press", press, tbl[i].prs);
            chk("tbl_release", rel, tbl[i].rls);
            chk("tbl_debounced", debounced, tbl[i].deb);
        end

        // HOLD: short press whose release lands inside the hold window
        repeat (3) step(0, 2'b00, 2'b10);
        hold_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(0, (k < 5) ? 2'b01 : 2'b00, 2'b10);
            if (debounced[0]) hold_cnt++;
            if (k == 10) begin
                chk("hold_release_level", level[0], 1'b0);
                chk("hold_over_release", debounced[0], 1'b1);
            end
            if (k == 11) chk("hold_end", debounced[0], 1'b0);
        end
        chk("hold_len", hold_cnt, HLD);

        // REPEAT: ch1 high long enough that a repeat would land on the falling edge
        repeat (3) step(0, 2'b00, 2'b11);
        n_pulse = 0;
        for (int k = 0; k < 55; k++) begin
            step(0, (k < 37) ? 2'b10 : 2'b00, 2'b11);
            e = (k >= 5) && (k - 5 < 37) &&
                ((k == 5) || (k - 5 >= RD && (k - 5 - RD) % RP == 0));
            chk("rpt_pulse", debounced[1], e);
            if (debounced[1]) n_pulse++;
        end
        chk("rpt_count", n_pulse, 10);

        // PULSE: both channels rise together
        repeat (3) step(0, 2'b00, 2'b01);
        for (int k = 0; k < 16; k++) begin
            step(0, (k < 8) ? 2'b11 : 2'b00, 2'b01);
            if (k == 4) chk("pulse_before", press, 2'b00);
            if (k == 5) begin
                chk("pulse_press", press, 2'b11);
                chk("pulse_deb", debounced, 2'b11);
            end
            if (k == 6) begin
                chk("pulse_press_after", press, 2'b00);
                chk("pulse_deb_after", debounced, 2'b00);
            end
        end

        // Reset in the middle of a hold, then re-debounce of a still-high input
        repeat (3) step(0, 2'b00, 2'b10);
        for (int k = 0; k < 8; k++) step(0, 2'b01, 2'b10);
        chk("hold_active", debounced[0], 1'b1);
        step(1, 2'b01, 2'b10);
        chk("rst_level", level, 2'b00);
        chk("rst_press", press, 2'b00);
        chk("rst_release", rel, 2'b00);
        chk("rst_deb", debounced, 2'b00);
        for (int k = 0; k < 8; k++) begin
            step(0, 2'b01, 2'b10);
            if (k == 4) chk("post_rst_level_low", level[0], 1'b0);
            if (k == 5) chk("post_rst_level_high", level[0], 1'b1);
        end

        // Mode change in the middle of a repeat delay
        step(0, 2'b11, 2'b11);
        for (int k = 1; k < 8; k++) begin
            step(0, 2'b11, 2'b11);
            if (k == 5) chk("rpt_first", debounced[1], 1'b1);
        end
        step(0, 2'b11, 2'b00);
        chk("mode_chg_deb", debounced, 2'b00);
        step(0, 2'b11, 2'b00);
        chk("level_mode_deb", debounced, 2'b11);
        step(0, 2'b11, 2'b11);
        chk("mode_back_deb", debounced, 2'b00);
        for (int k = 0; k < 15; k++) begin
            step(0, 2'b11, 2'b11);
            chk("rpt_idle_quiet", debounced, 2'b00);
        end
        repeat (8) step(0, 2'b00, 2'b11);

        // Randomized runs of held levels, glitches, mode changes and resets
        rm = 2'b11;
        rs = '0;
        for (int c = 0; c < CH; c++) run[c] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (run[c] == 0) begin
                    rs[c]  = 1'($urandom_range(0, 1));
                    run[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
                end
                run[c]--;
            end
            if ($urandom_range(0, 199) == 0) rm = 2'($urandom_range(0, 3));
            rr = ($urandom_range(0, 999) == 0);
            step(rr, rs, rm);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent input channels (>=1).
REQ-002 Parameter CNT_W, default 26, width of every per-channel counter.
REQ-003 Parameter STABLE_CYCLES, default 500000, consecutive differing cycles required to accept a new level (>=1, <2^CNT_W).
REQ-004 Parameter HOLD_CYCLES, default 25000000, output-high duration in HOLD mode (>=1, <2^CNT_W).
REQ-005 Parameter RPT_DELAY, default 25000000, and RPT_PERIOD, default 5000000, set the first-repeat delay and the repeat interval in REPEAT mode (both >=1, <2^CNT_W).
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 signal  input  CHANNELS  raw asynchronous inputs, one bit per channel.
REQ-009 mode  input  2  global output mode: 00 LEVEL, 01 PULSE, 10 HOLD, 11 REPEAT.
REQ-010 level  output  CHANNELS  debounced level per channel.
REQ-011 press  output  CHANNELS  one-cycle pulse on each debounced rising edge.
REQ-012 release  output  CHANNELS  one-cycle pulse on each debounced falling edge.
REQ-013 debounced  output  CHANNELS  mode-dependent output per channel.

Function
REQ-014 Each channel passes signal through a 2-flop synchronizer before any use.
REQ-015 Stability counter: +1 each cycle the synchronized bit != level; cleared to 0 on any cycle they are equal.
REQ-016 When the synchronized bit != level and the counter == STABLE_CYCLES-1: level <= synchronized bit and counter <= 0 on that edge.
REQ-017 Latency: raw change captured at edge 0 with no glitch -> level changes at edge 1+STABLE_CYCLES.
REQ-018 A glitch shorter than STABLE_CYCLES synchronized cycles leaves level, press and release unchanged.
REQ-019 press/release are registered and high for exactly the one cycle following the edge at which level rises/falls.
REQ-020 Channels are fully independent; simultaneous events on several channels are each handled in the same cycle.
REQ-021 Per-channel FSM states: IDLE, HOLD, RPT_DELAY, RPT_RUN; per-channel timer of CNT_W bits.
REQ-022 LEVEL: debounced = level; FSM stays IDLE.
REQ-023 PULSE: debounced = press; FSM stays IDLE.
REQ-024 HOLD: press in IDLE -> HOLD, debounced = 1 for exactly HOLD_CYCLES cycles, then IDLE with debounced = 0.
REQ-025 HOLD: release and further press pulses during HOLD are ignored; a new hold requires a new press seen in IDLE.
REQ-026 REPEAT: press in IDLE -> one-cycle debounced pulse, then RPT_DELAY.
REQ-027 REPEAT: after RPT_DELAY cycles in RPT_DELAY with level still 1 -> one-cycle pulse, enter RPT_RUN.
REQ-028 REPEAT: in RPT_RUN, one-cycle pulse every RPT_PERIOD cycles while level = 1.
REQ-029 REPEAT: level = 0 in RPT_DELAY or RPT_RUN -> IDLE on the next edge, no further pulses; a pulse coinciding with the falling edge of level is suppressed.
REQ-030 A change of mode (mode differs from its value on the previous cycle) forces every FSM to IDLE, clears the timers, and drives debounced to 0 for that cycle.
REQ-031 level, press and release keep operating across mode changes.
REQ-032 Timers never wrap; they are compared for equality with the parameter minus 1 and cleared on every state transition.

Reset
REQ-033 rst = 1 at an edge clears synchronizers, counters, timers, level, press, release and debounced to 0 and sets all FSMs to IDLE.
REQ-034 rst overrides all other activity, including mid-HOLD and mid-REPEAT.
REQ-035 After rst deasserts, a signal already high is debounced normally (level rises at edge 1+STABLE_CYCLES after release of reset).

Verification
Use CHANNELS=2, STABLE_CYCLES=4, HOLD_CYCLES=6, RPT_DELAY=10, RPT_PERIOD=3.
REQ-036 LEVEL mode, ch0 raw 0->1 held -> level[0]=1 exactly 5 edges after capture; press[0] high 1 cycle; ch1 unchanged.
REQ-037 Raw ch0 high for 3 cycles, then low -> level, press and debounced stay 0 throughout.
REQ-038 HOLD mode, ch0 press then release after 2 cycles -> debounced[0] high exactly 6 cycles, then 0; second press during hold ignored.
REQ-039 REPEAT mode, ch1 held 30 cycles after level rises -> debounced[1] pulses at offsets 0, 10, 13, 16, 19, ...; none after level falls.
REQ-040 Both channels rise on the same cycle in PULSE mode -> press=2'b11 and debounced=2'b11 for one cycle.
REQ-041 rst asserted mid-HOLD and mode changed mid-REPEAT -> all outputs 0 on the next cycle; FSMs in IDLE.
